// File: rtl/mac_pkg.sv
// Shared types and default widths for the MAC datapath blocks.
package mac_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int MAC_DATA_W     = 8;
  localparam int MAC_ACC_W      = 12;
  localparam int MAC_BRAM_DEPTH = 5;
  localparam int MAC_ADDR_W     = 3;

  // Number of zero bits prepended when widening a product to accumulator width
  localparam int MAC_ZEXT_W     = MAC_ACC_W - MAC_DATA_W;

endpackage

// File: rtl/mac_result_writer.sv
// Takes multiplier products over valid/ready, optionally accumulates them and
// writes one frame of DEPTH results into a single-port result BRAM.
module mac_result_writer
  import mac_pkg::*;
#(
  parameter int DATA_W = MAC_DATA_W,
  parameter int ACC_W  = MAC_ACC_W,
  parameter int DEPTH  = MAC_BRAM_DEPTH,
  parameter int ADDR_W = MAC_ADDR_W,
  parameter int ACCUM  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              bram_ena,
  output logic              bram_wea,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [ACC_W-1:0]  bram_dina,
  output logic              busy,
  output logic              done,
  output logic [ACC_W-1:0]  acc_out
);

  state_t              r_state;
  state_t              w_state_next;
  logic [ADDR_W-1:0]   r_wr_ptr;
  logic [ACC_W-1:0]    r_acc;
  logic                r_bram_we;
  logic [ADDR_W-1:0]   r_bram_addr;
  logic [ACC_W-1:0]    r_bram_dina;

  logic                w_run;
  logic                w_accept;
  logic                w_last;
  logic                w_new_frame;
  logic [ACC_W-1:0]    w_data_ext;
  logic [ACC_W-1:0]    w_acc_new;

  assign w_run       = (r_state == ST_RUN);
  assign w_accept    = in_valid & w_run;
  assign w_last      = (r_wr_ptr == ADDR_W'(DEPTH - 1));
  assign w_new_frame = start & ~w_run;
  assign w_data_ext  = ACC_W'(in_data);
  // Sum wraps silently at ACC_W bits
  assign w_acc_new   = (ACCUM != 0) ? (r_acc + w_data_ext) : w_data_ext;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (start) w_state_next = ST_RUN;
      ST_RUN:  if (w_accept && w_last) w_state_next = ST_DONE;
      ST_DONE: if (start) w_state_next = ST_RUN;
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_wr_ptr    <= '0;
      r_acc       <= '0;
      r_bram_we   <= 1'b0;
      r_bram_addr <= '0;
      r_bram_dina <= '0;
    end else begin
      r_state   <= w_state_next;
      r_bram_we <= w_accept;
      if (w_accept) begin
        r_bram_addr <= r_wr_ptr;
        r_bram_dina <= w_acc_new;
        r_acc       <= w_acc_new;
        r_wr_ptr    <= w_last ? '0 : r_wr_ptr + ADDR_W'(1);
      end else if (w_new_frame) begin
        r_wr_ptr <= '0;
        r_acc    <= '0;
      end
    end
  end

  assign in_ready  = w_run;
  assign busy      = w_run;
  assign done      = (r_state == ST_DONE);
  assign bram_ena  = r_bram_we;
  assign bram_wea  = r_bram_we;
  assign bram_addr = r_bram_addr;
  assign bram_dina = r_bram_dina;
  assign acc_out   = r_acc;

endmodule

// File: tb/tb_mac_result_writer.sv
// Bench for mac_result_writer: three configurations (MAC 12b, pass-through, MAC 8b)
// driven with the same stimulus and checked against a frame-level reference model.
module tb_mac_result_writer;

  localparam int NI = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic in_valid = 1'b0;
  logic [7:0] in_data = '0;

  always #5 clk = ~clk;

  logic        o_ready [NI];
  logic        o_ena   [NI];
  logic        o_wea   [NI];
  logic [2:0]  o_addr  [NI];
  logic [11:0] o_dina  [NI];
  logic        o_busy  [NI];
  logic        o_done  [NI];
  logic [11:0] o_acc   [NI];

  logic [7:0] dina2, acc2;

  mac_result_writer #(.DATA_W(8), .ACC_W(12), .DEPTH(5), .ADDR_W(3), .ACCUM(1)) u_mac12 (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(o_ready[0]), .bram_ena(o_ena[0]), .bram_wea(o_wea[0]), .bram_addr(o_addr[0]),
    .bram_dina(o_dina[0]), .busy(o_busy[0]), .done(o_done[0]), .acc_out(o_acc[0]));

  mac_result_writer #(.DATA_W(8), .ACC_W(12), .DEPTH(5), .ADDR_W(3), .ACCUM(0)) u_pass (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(o_ready[1]), .bram_ena(o_ena[1]), .bram_wea(o_wea[1]), .bram_addr(o_addr[1]),
    .bram_dina(o_dina[1]), .busy(o_busy[1]), .done(o_done[1]), .acc_out(o_acc[1]));

  mac_result_writer #(.DATA_W(8), .ACC_W(8), .DEPTH(5), .ADDR_W(3), .ACCUM(1)) u_mac8 (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(o_ready[2]), .bram_ena(o_ena[2]), .bram_wea(o_wea[2]), .bram_addr(o_addr[2]),
    .bram_dina(dina2), .busy(o_busy[2]), .done(o_done[2]), .acc_out(acc2));

  assign o_dina[2] = {4'b0000, dina2};
  assign o_acc[2]  = {4'b0000, acc2};

  // Reference model: frame position, running value, and the last expected write
  int  cfg_accw  [NI] = '{12, 12, 8};
  int  cfg_accum [NI] = '{1, 0, 1};
  bit  m_run  [NI];
  bit  m_done [NI];
  int  m_idx  [NI];
  int  m_sum  [NI];
  bit  m_wr   [NI];
  int  m_addr [NI];
  int  m_data [NI];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < NI; k++) begin
      m_run[k] = 0; m_done[k] = 0; m_idx[k] = 0; m_sum[k] = 0;
      m_wr[k] = 0; m_addr[k] = 0; m_data[k] = 0;
    end
  endtask

  task automatic model_step(input bit st, input bit v, input int d);
    for (int k = 0; k < NI; k++) begin
      int modv;
      modv = 1 << cfg_accw[k];
      m_wr[k] = 0;
      if (m_run[k] && v) begin
        m_sum[k]  = (cfg_accum[k] != 0) ? (m_sum[k] + d) % modv : d;
        m_wr[k]   = 1;
        m_addr[k] = m_idx[k];
        m_data[k] = m_sum[k];
        m_idx[k]  = m_idx[k] + 1;
        if (m_idx[k] == 5) begin
          m_idx[k] = 0; m_run[k] = 0; m_done[k] = 1;
        end
      end else if (st && !m_run[k]) begin
        m_run[k] = 1; m_done[k] = 0; m_idx[k] = 0; m_sum[k] = 0;
      end
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < NI; k++) begin
      check_eq($sformatf("ready%0d", k), int'(o_ready[k]), int'(m_run[k]));
      check_eq($sformatf("busy%0d", k),  int'(o_busy[k]),  int'(m_run[k]));
      check_eq($sformatf("done%0d", k),  int'(o_done[k]),  int'(m_done[k]));
      check_eq($sformatf("ena%0d", k),   int'(o_ena[k]),   int'(m_wr[k]));
      check_eq($sformatf("wea%0d", k),   int'(o_wea[k]),   int'(m_wr[k]));
      check_eq($sformatf("addr%0d", k),  int'(o_addr[k]),  m_addr[k]);
      check_eq($sformatf("dina%0d", k),  int'(o_dina[k]),  m_data[k]);
      check_eq($sformatf("acc%0d", k),   int'(o_acc[k]),   m_sum[k]);
    end
  endtask

  // One clock of stimulus: inputs change on the falling edge, outputs sampled 1 ns after the rise
  task automatic cycle(input bit st, input bit v, input int d);
    @(negedge clk);
    start = st; in_valid = v; in_data = 8'(d);
    @(posedge clk);
    model_step(st, v, d);
    #1;
    $display("cyc st=%0d v=%0d d=%0d | wr=%0d addr=%0d dina=%0d/%0d/%0d done=%0d",
             st, v, d, o_wea[0], o_addr[0], o_dina[0], o_dina[1], o_dina[2], o_done[0]);
    check_all();
  endtask

  task automatic check_zero_outputs(input string tag);
    for (int k = 0; k < NI; k++) begin
      check_eq($sformatf("%s_out%0d", tag, k),
               int'(o_ready[k]) + int'(o_ena[k]) + int'(o_wea[k]) + int'(o_addr[k]) +
               int'(o_dina[k]) + int'(o_busy[k]) + int'(o_done[k]) + int'(o_acc[k]), 0);
    end
  endtask

  int seq_a [5] = '{3, 5, 7, 2, 4};
  int seq_b [5] = '{225, 10, 0, 255, 1};

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_zero_outputs("rst");
    @(negedge clk);
    rst_n = 1'b1;
    cycle(0, 1, 9);
    cycle(0, 0, 0);

    // Back-to-back frame
    cycle(1, 0, 0);
    for (int i = 0; i < 5; i++) cycle(0, 1, seq_a[i]);
    check_eq("seqA_addr", int'(o_addr[0]), 4);
    check_eq("seqA_data", int'(o_dina[0]), 21);
    check_eq("seqA_done", int'(o_done[0]), 1);
    cycle(0, 1, 6);
    check_eq("seqA_ready_after", int'(o_ready[0]), 0);

    // Gapped valid; pass-through instance should see raw products
    cycle(1, 0, 0);
    for (int i = 0; i < 5; i++) begin
      cycle(0, 1, seq_b[i]);
      if (i == 3) check_eq("seqB_255", int'(o_dina[1]), 255);
      cycle(0, 0, 77);
    end
    check_eq("seqB_last_addr", int'(o_addr[1]), 4);
    check_eq("seqB_last_data", int'(o_dina[1]), 1);

    // Overflow in the 8-bit MAC, start ignored in RUN, restart from DONE with pending write
    cycle(1, 0, 0);
    cycle(0, 1, 200);
    cycle(0, 1, 100);
    check_eq("ovf_data8", int'(o_dina[2]), 44);
    check_eq("ovf_data12", int'(o_dina[0]), 300);
    cycle(1, 0, 0);
    check_eq("run_start_busy", int'(o_busy[0]), 1);
    cycle(1, 1, 1);
    check_eq("run_start_addr", int'(o_addr[0]), 2);
    cycle(0, 1, 2);
    cycle(0, 1, 3);
    cycle(1, 0, 0);
    check_eq("restart_done_clr", int'(o_done[0]), 0);
    cycle(0, 1, 9);
    check_eq("restart_addr", int'(o_addr[0]), 0);
    check_eq("restart_data", int'(o_dina[0]), 9);

    // Randomised traffic
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 7) == 0), ($urandom_range(0, 3) != 0), int'($urandom_range(0, 255)));
    end

    // Reset asserted during the write cycle of the third accept
    repeat (6) cycle(0, 1, 1);
    cycle(1, 0, 0);
    cycle(0, 1, 11);
    cycle(0, 1, 22);
    cycle(0, 1, 33);
    check_eq("mid_wea_before", int'(o_wea[0]), 1);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_zero_outputs("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    cycle(0, 1, 44);
    check_eq("post_rst_ready", int'(o_ready[0]), 0);
    cycle(1, 0, 0);
    cycle(0, 1, 5);
    check_eq("post_rst_addr", int'(o_addr[0]), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
